// File: rtl/mux7_rr_arbiter.sv
// mux7_rr_arbiter: round-robin scheduler sharing one mux7to1 among requesters A..G
// Ports:
//   clk   - clock, all state updates on posedge
//   rst   - asynchronous active-high reset
//   Req   - level request lines, Req[0]=A .. Req[6]=G
//   Gnt   - registered one-hot grant, zero when idle
//   Sel   - mux select, binary index of the current (or last) owner
//   Valid - high while a grant is active
module mux7_rr_arbiter #(
    parameter int MAX_HOLD = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] Req,
    output logic [6:0] Gnt,
    output logic [2:0] Sel,
    output logic       Valid
);
    typedef enum logic {IDLE, GRANT} state_t;
    localparam logic [3:0] LIM = 4'(MAX_HOLD - 1);
    state_t     state;
    logic [2:0] ptr;
    logic [3:0] cnt;
    logic [2:0] base;
    logic [2:0] win;
    logic       found;
    logic       keep;
    // Modulo-7 add; operands never exceed 6, so one correction suffices.
    function automatic logic [2:0] add7(input logic [2:0] a, input logic [2:0] b);
        logic [3:0] s;
        s = {1'b0, a} + {1'b0, b};
        return (s >= 4'd7) ? 3'(s - 4'd7) : s[2:0];
    endfunction
    assign keep = (state == GRANT) && Req[Sel] && (cnt < LIM);
    // Scan from the highest offset down so the closest requester to base wins.
    always_comb begin
        base  = (state == GRANT) ? add7(Sel, 3'd1) : ptr;
        found = 1'b0;
        win   = 3'd0;
        for (int i = 6; i >= 0; i--) begin
            if (Req[add7(base, 3'(i))]) begin
                found = 1'b1;
                win   = add7(base, 3'(i));
            end
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            Gnt   <= 7'd0;
            Sel   <= 3'd0;
            Valid <= 1'b0;
            ptr   <= 3'd0;
            cnt   <= 4'd0;
        end else if (keep) begin
            cnt <= cnt + 4'd1;
        end else if (found) begin
            state <= GRANT;
            Sel   <= win;
            Gnt   <= 7'd1 << win;
            Valid <= 1'b1;
            cnt   <= 4'd0;
            ptr   <= add7(win, 3'd1);
        end else begin
            state <= IDLE;
            Gnt   <= 7'd0;
            Valid <= 1'b0;
        end
    end
endmodule
